// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

    // Access width/sign encodings carried on funct3.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_width_e;

    // Bus-side sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Byte-enable patterns; byte enables for sub-word accesses shift from these.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Width of the bus timeout counter; holds any wait limit up to 255.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering, load extraction/extension and the
// alignment/legality check. Purely combinational so a cache path can reuse it.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    input  logic        is_load,
    input  logic        is_store,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        addr_fault,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_value
);

    logic        misaligned;
    logic        illegal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Byte enables and lane-replicated write data from width and address offset.
    always_comb begin
        st_be    = BE_NONE;
        st_wdata = st_data;
        case (st_funct3)
            MEM_B, MEM_BU: begin
                st_be    = BE_BYTE0 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            MEM_H, MEM_HU: begin
                st_be    = st_offset[1] ? BE_HALF_HI : BE_HALF_LO;
                st_wdata = {2{st_data[15:0]}};
            end
            MEM_W:   st_be = BE_WORD;
            default: st_be = BE_NONE;
        endcase
    end

    // Misalignment by width, plus funct3 codes that have no meaning for this access kind.
    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (st_funct3)
            MEM_B, MEM_BU: misaligned = 1'b0;
            MEM_H, MEM_HU: misaligned = st_offset[0];
            MEM_W:         misaligned = |st_offset;
            default:       illegal    = 1'b1;
        endcase
        if (is_store && st_funct3[2]) begin
            illegal = 1'b1;
        end
        addr_fault = (is_load || is_store) && (misaligned || illegal);
    end

    // Pick the addressed byte/half out of the read word and extend it to 32 bits.
    always_comb begin
        ld_value = ld_rdata;
        case (ld_offset)
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            2'd3:    ld_byte = ld_rdata[31:24];
            default: ld_byte = ld_rdata[7:0];
        endcase
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            MEM_B:   ld_value = {{24{ld_byte[7]}}, ld_byte};
            MEM_BU:  ld_value = {24'h000000, ld_byte};
            MEM_H:   ld_value = {{16{ld_half[15]}}, ld_half};
            MEM_HU:  ld_value = {16'h0000, ld_half};
            default: ld_value = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: takes execute results, runs a request/grant/
// rvalid data-memory access with timeout, and hands results to writeback.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr,
    input  logic        reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_reg_write,
    output logic        wb_addr_fault,
    output logic        wb_bus_err
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C = MAX_WAIT[CNT_W-1:0];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_next;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             is_store_q, is_store_d;
    logic [4:0]       rd_q, rd_d;
    logic             reg_write_q, reg_write_d;
    logic             dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [31:0]      dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [3:0]       dmem_be_q, dmem_be_d;
    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [4:0]       wb_rd_addr_q, wb_rd_addr_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic             wb_addr_fault_q, wb_addr_fault_d;
    logic             wb_bus_err_q, wb_bus_err_d;
    logic             accept, is_load, is_store, addr_fault;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata, ld_value;

    assign in_ready  = (state_q == ST_IDLE) && (!wb_valid_q || wb_ready);
    assign accept    = in_valid && in_ready;
    assign is_load   = mem_read;
    assign is_store  = mem_write && !mem_read;
    assign wait_next = wait_cnt_q + 1'b1;

    lsu_align u_align (
        .st_funct3  (funct3),
        .st_offset  (alu_result[1:0]),
        .st_data    (store_data),
        .is_load    (is_load),
        .is_store   (is_store),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .addr_fault (addr_fault),
        .ld_funct3  (funct3_q),
        .ld_offset  (addr_q[1:0]),
        .ld_rdata   (dmem_rdata),
        .ld_value   (ld_value)
    );

    // Next-state logic: accept/fault/pass-through in IDLE, request until granted, then wait for a response or timeout.
    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        addr_d          = addr_q;
        funct3_d        = funct3_q;
        is_store_d      = is_store_q;
        rd_d            = rd_q;
        reg_write_d     = reg_write_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_be_d       = dmem_be_q;
        dmem_wdata_d    = dmem_wdata_q;
        wb_valid_d      = wb_ready ? 1'b0 : wb_valid_q;
        wb_data_d       = wb_data_q;
        wb_rd_addr_d    = wb_rd_addr_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_addr_fault_d = wb_addr_fault_q;
        wb_bus_err_d    = wb_bus_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if ((!is_load && !is_store) || addr_fault) begin
                        wb_valid_d      = 1'b1;
                        wb_data_d       = alu_result;
                        wb_rd_addr_d    = rd_addr;
                        wb_reg_write_d  = reg_write && !addr_fault;
                        wb_addr_fault_d = addr_fault;
                        wb_bus_err_d    = 1'b0;
                    end else begin
                        state_d      = ST_REQ;
                        addr_d       = alu_result;
                        funct3_d     = funct3;
                        is_store_d   = is_store;
                        rd_d         = rd_addr;
                        reg_write_d  = reg_write;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {alu_result[31:2], 2'b00};
                        dmem_be_d    = st_be;
                        dmem_wdata_d = st_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    state_d    = ST_WAIT;
                    dmem_req_d = 1'b0;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    state_d         = ST_IDLE;
                    dmem_we_d       = 1'b0;
                    wb_valid_d      = 1'b1;
                    wb_data_d       = is_store_q ? addr_q : ld_value;
                    wb_rd_addr_d    = rd_q;
                    wb_reg_write_d  = reg_write_q && !is_store_q;
                    wb_addr_fault_d = 1'b0;
                    wb_bus_err_d    = 1'b0;
                end else if (wait_next == MAX_WAIT_C) begin
                    state_d         = ST_IDLE;
                    dmem_we_d       = 1'b0;
                    wb_valid_d      = 1'b1;
                    wb_data_d       = addr_q;
                    wb_rd_addr_d    = rd_q;
                    wb_reg_write_d  = 1'b0;
                    wb_addr_fault_d = 1'b0;
                    wb_bus_err_d    = 1'b1;
                end else begin
                    wait_cnt_d = wait_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops the bus request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wait_cnt_q      <= '0;
            addr_q          <= '0;
            funct3_q        <= '0;
            is_store_q      <= 1'b0;
            rd_q            <= '0;
            reg_write_q     <= 1'b0;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_be_q       <= '0;
            dmem_wdata_q    <= '0;
            wb_valid_q      <= 1'b0;
            wb_data_q       <= '0;
            wb_rd_addr_q    <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_addr_fault_q <= 1'b0;
            wb_bus_err_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            addr_q          <= addr_d;
            funct3_q        <= funct3_d;
            is_store_q      <= is_store_d;
            rd_q            <= rd_d;
            reg_write_q     <= reg_write_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_be_q       <= dmem_be_d;
            dmem_wdata_q    <= dmem_wdata_d;
            wb_valid_q      <= wb_valid_d;
            wb_data_q       <= wb_data_d;
            wb_rd_addr_q    <= wb_rd_addr_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_addr_fault_q <= wb_addr_fault_d;
            wb_bus_err_q    <= wb_bus_err_d;
        end
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_be       = dmem_be_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd_addr    = wb_rd_addr_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_addr_fault = wb_addr_fault_q;
    assign wb_bus_err    = wb_bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: hand-written vector table, directed
// backpressure/reset sequences, and randomized transactions against a model.
module tb_mem_stage;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_ready, wb_reg_write, wb_addr_fault, wb_bus_err;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        mr, mw;
        logic [2:0]  f3;
        logic [31:0] alu, sd;
        logic [4:0]  rda;
        logic        rw;
        logic [31:0] rdata;
        int          gnt_dly, rv_dly;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_wb;
        logic        e_rw, e_fault, e_berr;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic        req, we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata, wb;
        logic [4:0]  rda;
        logic        rw, fault, berr;
        int          lat;
    } obs_t;

    vec_t tbl[17];

    mem_stage #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .alu_result(alu_result), .store_data(store_data), .rd_addr(rd_addr),
        .reg_write(reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .wb_addr_fault(wb_addr_fault), .wb_bus_err(wb_bus_err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Watchdog so a stuck run still terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: expected outcome derived from the access rules with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   r = v;
        logic   ld, st, legal, fault, tmo;
        int     size, off;
        longint raw, half;
        logic [31:0] sh;
        ld   = v.mr;
        st   = v.mw && !v.mr;
        size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : (v.f3[1:0] == 2'd2) ? 4 : 0;
        off  = int'(v.alu[1:0]);
        legal = ld ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 < 3'd3);
        fault = 1'b0;
        if (ld || st) fault = !legal || ((off % size) != 0);
        r.e_req   = (ld || st) && !fault;
        tmo       = r.e_req && (v.rv_dly >= MAXW);
        r.e_we    = st;
        r.e_addr  = v.alu - 32'(off);
        r.e_be    = 4'(((1 << size) - 1) << off);
        r.e_wdata = (size == 1) ? 32'(v.sd[7:0]) * 32'h0101_0101 :
                    (size == 2) ? 32'(v.sd[15:0]) * 32'h0001_0001 : v.sd;
        sh = v.rdata >> (8 * off);
        if (size == 4) begin
            raw = longint'(sh);
        end else begin
            raw  = longint'(sh) % (64'sd1 <<< (8 * size));
            half = 64'sd1 <<< (8 * size - 1);
            if (!v.f3[2] && raw >= half) raw = raw - 2 * half;
        end
        r.e_wb    = (ld && r.e_req) ? raw[31:0] : v.alu;
        r.e_fault = fault;
        r.e_berr  = tmo;
        r.e_rw    = v.rw && !fault && !tmo && !st;
        r.e_lat   = !r.e_req ? 1 : v.gnt_dly + (tmo ? MAXW - 1 : v.rv_dly) + 3;
        return r;
    endfunction

    // Issue one instruction and act as the memory: grant after gnt_dly REQ cycles, respond after rv_dly WAIT cycles.
    task automatic applyStimulus(input vec_t v, output obs_t o);
        logic granted, g, rv;
        int   wc, rc;
        o = '{req: 0, we: 0, addr: 0, be: 0, wdata: 0, wb: 0, rda: 0, rw: 0, fault: 0, berr: 0, lat: -1};
        mem_read = v.mr; mem_write = v.mw; funct3 = v.f3; alu_result = v.alu;
        store_data = v.sd; rd_addr = v.rda; reg_write = v.rw; dmem_rdata = v.rdata;
        in_valid = 1'b1;
        checkOutput("in_ready_at_issue", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        granted = 1'b0; wc = 0; rc = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (wb_valid) begin
                o.wb = wb_data; o.rda = wb_rd_addr; o.rw = wb_reg_write;
                o.fault = wb_addr_fault; o.berr = wb_bus_err; o.lat = cyc;
                break;
            end
            rv = granted && (wc == v.rv_dly);
            if (granted) wc++;
            g = 1'b0;
            if (dmem_req && !granted) begin
                o.req = 1'b1; o.we = dmem_we; o.addr = dmem_addr;
                o.be = dmem_be; o.wdata = dmem_wdata;
                if (rc == v.gnt_dly) g = 1'b1;
                rc++;
            end
            dmem_gnt = g; dmem_rvalid = rv;
            @(posedge clk); #1;
            if (g) granted = 1'b1;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic checkVec(input vec_t v, input string tag);
        obs_t o;
        applyStimulus(v, o);
        checkOutput({tag, ".req"}, 32'(o.req), 32'(v.e_req));
        if (v.e_req) begin
            checkOutput({tag, ".we"}, 32'(o.we), 32'(v.e_we));
            checkOutput({tag, ".addr"}, o.addr, v.e_addr);
            checkOutput({tag, ".be"}, 32'(o.be), 32'(v.e_be));
            if (v.e_we) checkOutput({tag, ".wdata"}, o.wdata, v.e_wdata);
        end
        checkOutput({tag, ".rd"}, 32'(o.rda), 32'(v.rda));
        checkOutput({tag, ".reg_write"}, 32'(o.rw), 32'(v.e_rw));
        checkOutput({tag, ".fault"}, 32'(o.fault), 32'(v.e_fault));
        checkOutput({tag, ".bus_err"}, 32'(o.berr), 32'(v.e_berr));
        if (!v.e_fault && !v.e_berr) checkOutput({tag, ".wb_data"}, o.wb, v.e_wb);
        checkOutput({tag, ".latency"}, 32'(o.lat), 32'(v.e_lat));
    endtask

    initial begin
        vec_t v;
        // mr mw f3 alu sd rd rw rdata gd rvd | req we addr be wdata wb rw fault berr lat
        tbl[0]  = '{0,0,3'd2,32'h0000_1234,32'h0,5'd5,1,32'h0,0,0,        0,0,32'h0,4'h0,32'h0,32'h0000_1234,1,0,0,1};
        tbl[1]  = '{1,0,3'd0,32'h0000_0103,32'h0,5'd3,1,32'h80AA_BBCC,0,0, 1,0,32'h100,4'b1000,32'h0,32'hFFFF_FF80,1,0,0,3};
        tbl[2]  = '{1,0,3'd4,32'h0000_0103,32'h0,5'd3,1,32'h80AA_BBCC,0,0, 1,0,32'h100,4'b1000,32'h0,32'h0000_0080,1,0,0,3};
        tbl[3]  = '{0,1,3'd1,32'h0000_0202,32'h1234_ABCD,5'd9,1,32'h0,0,0, 1,1,32'h200,4'b1100,32'hABCD_ABCD,32'h0000_0202,0,0,0,3};
        tbl[4]  = '{1,0,3'd2,32'h0000_0101,32'h0,5'd4,1,32'h0,0,0,        0,0,32'h0,4'h0,32'h0,32'h0,0,1,0,1};
        tbl[5]  = '{1,0,3'd3,32'h0000_0100,32'h0,5'd4,1,32'h0,0,0,        0,0,32'h0,4'h0,32'h0,32'h0,0,1,0,1};
        tbl[6]  = '{1,0,3'd5,32'h0000_0102,32'h0,5'd6,1,32'h80AA_BBCC,0,0, 1,0,32'h100,4'b1100,32'h0,32'h0000_80AA,1,0,0,3};
        tbl[7]  = '{1,0,3'd1,32'h0000_0100,32'h0,5'd7,1,32'h1234_F00D,2,1, 1,0,32'h100,4'b0011,32'h0,32'hFFFF_F00D,1,0,0,6};
        tbl[8]  = '{1,0,3'd2,32'h0000_0204,32'h0,5'd8,1,32'hDEAD_BEEF,1,0, 1,0,32'h204,4'b1111,32'h0,32'hDEAD_BEEF,1,0,0,4};
        tbl[9]  = '{0,1,3'd0,32'h0000_0301,32'h1122_3344,5'd1,1,32'h0,0,0, 1,1,32'h300,4'b0010,32'h4444_4444,32'h0000_0301,0,0,0,3};
        tbl[10] = '{0,1,3'd2,32'h0000_0400,32'hCAFE_F00D,5'd2,1,32'h0,0,0, 1,1,32'h400,4'b1111,32'hCAFE_F00D,32'h0000_0400,0,0,0,3};
        tbl[11] = '{1,1,3'd0,32'h0000_0101,32'hFFFF_FFFF,5'd10,1,32'h0000_7F00,0,0, 1,0,32'h100,4'b0010,32'h0,32'h0000_007F,1,0,0,3};
        tbl[12] = '{0,1,3'd4,32'h0000_0100,32'h0,5'd11,1,32'h0,0,0,       0,0,32'h0,4'h0,32'h0,32'h0,0,1,0,1};
        tbl[13] = '{0,1,3'd1,32'h0000_0203,32'h0,5'd12,1,32'h0,0,0,       0,0,32'h0,4'h0,32'h0,32'h0,0,1,0,1};
        tbl[14] = '{1,0,3'd2,32'h0000_0010,32'h0,5'd13,1,32'h0,0,10,      1,0,32'h10,4'b1111,32'h0,32'h0,0,0,1,6};
        tbl[15] = '{1,0,3'd2,32'h0000_0014,32'h0,5'd14,1,32'h5A5A_1234,0,3, 1,0,32'h14,4'b1111,32'h0,32'h5A5A_1234,1,0,0,6};
        tbl[16] = '{0,0,3'd7,32'h0000_0203,32'h0,5'd15,0,32'h0,0,0,       0,0,32'h0,4'h0,32'h0,32'h0000_0203,0,0,0,1};

        rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        alu_result = '0; store_data = '0; rd_addr = '0; reg_write = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; wb_ready = 1'b1;

        // Reset state.
        #12;
        checkOutput("rst.dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rst.dmem_we", 32'(dmem_we), 32'd0);
        checkOutput("rst.dmem_addr", dmem_addr, 32'd0);
        checkOutput("rst.dmem_be", 32'(dmem_be), 32'd0);
        checkOutput("rst.wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst.wb_data", wb_data, 32'd0);
        checkOutput("rst.wb_reg_write", 32'(wb_reg_write), 32'd0);
        checkOutput("rst.wb_flags", {30'd0, wb_addr_fault, wb_bus_err}, 32'd0);
        checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < 17; i++) begin
            checkVec(tbl[i], $sformatf("tbl[%0d]", i));
        end
        checkOutput("after_timeout.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Backpressure: result held while wb_ready is low, new instruction refused.
        wb_ready = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; alu_result = 32'hAAAA_5555; rd_addr = 5'd7; reg_write = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp.wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("bp.wb_data", wb_data, 32'hAAAA_5555);
        mem_read = 1'b1; funct3 = 3'd2; alu_result = 32'h0000_0500; rd_addr = 5'd20;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp.in_ready[%0d]", k), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            checkOutput($sformatf("bp.hold_valid[%0d]", k), 32'(wb_valid), 32'd1);
            checkOutput($sformatf("bp.hold_data[%0d]", k), wb_data, 32'hAAAA_5555);
            checkOutput($sformatf("bp.hold_rd[%0d]", k), 32'(wb_rd_addr), 32'd7);
            checkOutput($sformatf("bp.hold_rw[%0d]", k), 32'(wb_reg_write), 32'd1);
            checkOutput($sformatf("bp.no_req[%0d]", k), 32'(dmem_req), 32'd0);
        end
        in_valid = 1'b0; mem_read = 1'b0; wb_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp.release_valid", 32'(wb_valid), 32'd0);
        checkOutput("bp.release_req", 32'(dmem_req), 32'd0);

        // Reset during REQ drops the request at once; a late response is ignored.
        mem_read = 1'b1; funct3 = 3'd2; alu_result = 32'h0000_0600; rd_addr = 5'd3; reg_write = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0;
        checkOutput("rstreq.req_up", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstreq.req_dropped", 32'(dmem_req), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("rstreq.no_wb[%0d]", k), 32'(wb_valid), 32'd0);
            checkOutput($sformatf("rstreq.no_req[%0d]", k), 32'(dmem_req), 32'd0);
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        checkOutput("rstreq.in_ready", 32'(in_ready), 32'd1);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 300; n++) begin
            int mode;
            mode      = int'($urandom_range(0, 3));
            v         = tbl[0];
            v.mr      = (mode == 1) || (mode == 3);
            v.mw      = (mode == 2) || (mode == 3);
            v.f3      = 3'($urandom_range(0, 7));
            v.alu     = $urandom;
            v.sd      = $urandom;
            v.rda     = 5'($urandom_range(0, 31));
            v.rw      = 1'($urandom_range(0, 1));
            v.rdata   = $urandom;
            v.gnt_dly = int'($urandom_range(0, 3));
            v.rv_dly  = int'($urandom_range(0, 5));
            v         = model(v);
            checkVec(v, $sformatf("rnd[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the ALU result as an address (or pass-through value), the store data and the load/store controls, and drives a data-memory request/grant/rvalid bus.
- Delivers an aligned, sign/zero-extended load value or the ALU result to writeback over a valid/ready handshake.
- Owns byte-lane steering, misalignment detection and a bus timeout.

Parameters:
- MAX_WAIT, 255: number of cycles spent in WAIT without dmem_rvalid before the access completes with a bus error (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- mem_read  in  1  load.
- mem_write  in  1  store.
- funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result  in  32  effective address, or the value to pass through.
- store_data  in  32  rs2 value.
- rd_addr  in  5  destination register.
- reg_write  in  1  destination register write enable.
- dmem_req  out  1  request; held until granted.
- dmem_we  out  1  write request.
- dmem_addr  out  32  word address; bits [1:0] always 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  response (read data or write ack); earliest one cycle after gnt.
- dmem_rdata  in  32  read word.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts the result.
- wb_data  out  32  load value or alu_result.
- wb_rd_addr  out  5  destination register.
- wb_reg_write  out  1  forced to 0 on any fault.
- wb_addr_fault  out  1  misaligned access or illegal funct3.
- wb_bus_err  out  1  timeout.

Behaviour:
- States: IDLE, REQ, WAIT. Output register has an independent wb_valid flag.
- Reset values: state IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write, wb_addr_fault, wb_bus_err are 0; all data/address outputs 0; timeout counter 0.
- in_ready = (state==IDLE) && (!wb_valid || wb_ready).
- Accept = in_valid && in_ready.
- Accept with neither mem_read nor mem_write: the next cycle has wb_valid=1, wb_data=alu_result, and ctrl copied. Latency 1.
- Accept with mem_read=1: treated as a load; mem_write is ignored when both are set.
- Fault check at accept:
  - B/BU: never misaligned.
  - H/HU: misaligned if addr[0]=1.
  - W: misaligned if addr[1:0]≠0.
  - Loads: funct3 011/110/111 are illegal. Stores: funct3 ≥011 are illegal.
  - On fault: no bus request; the next cycle has wb_valid=1, wb_addr_fault=1, wb_reg_write=0.
- Legal memory access: latch address/width/ctrl and go to REQ.
  - In REQ, dmem_req=1 with addr/be/wdata stable.
  - On dmem_gnt, go to WAIT and clear the counter.
- WAIT:
  - dmem_req=0 and the counter increments each cycle.
  - On dmem_rvalid: load the result (extracted/extended) or, for stores, wb_data=alu_result with wb_reg_write=0. Set wb_valid next cycle and go to IDLE.
  - If the counter reaches MAX_WAIT without rvalid: wb_bus_err=1, wb_reg_write=0, go to IDLE.
- Minimum load latency: accept at t0, req/gnt at t1, rvalid at t2, wb_valid at t3.
- Lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{byte}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: be = 1111.
- Load extraction:
  - Byte selected by addr[1:0]; half selected by addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- Output hold: wb_* are stable while wb_valid && !wb_ready. wb_valid clears on wb_ready unless a new result loads the same cycle.
- Backpressure: a pending memory access is not issued while wb_valid && !wb_ready, because in_ready is already 0.
- dmem_gnt outside REQ and dmem_rvalid outside WAIT are ignored.
- Reset mid-access returns to IDLE immediately and drops dmem_req asynchronously. A late rvalid after reset is ignored.

Decomposition:
- Package mem_pkg:
  - funct3 width enum (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
  - State enum.
  - BE constants.
- Sub-module lsu_align: combinational store lane steering, load extraction/extension and the fault check, shared with any future cache path.

Test Plan:
- Pass-through: in_valid, no mem, alu_result=0x0000_1234, rd=5 → next cycle wb_valid=1, wb_data=0x1234, wb_rd_addr=5, no dmem_req.
- LB at addr 0x103, rdata=0x80AA_BBCC, gnt immediate, rvalid next cycle → wb_data=0xFFFF_FF80 at t3; LBU gives 0x0000_0080; dmem_addr=0x100, be=1000.
- SH at 0x202 with store_data=0x1234_ABCD → dmem_we=1, be=1100, wdata=0xABCD_ABCD; after rvalid, wb_reg_write=0.
- LW at 0x101 → no dmem_req; wb_addr_fault=1, wb_reg_write=0; LH with funct3=011 → wb_addr_fault=1.
- Load granted with rvalid never arriving, MAX_WAIT=4 → wb_bus_err=1 after 4 WAIT cycles; state IDLE; in_ready=1.
- Hold wb_ready=0 for 3 cycles after a result → wb_* stable, in_ready=0. Assert rst_n=0 during REQ → dmem_req drops the same cycle; a subsequent rvalid produces no wb_valid.
